// File: rtl/wave_capture_pkg.sv
// Shared definitions for the wave capture path.
// Holds the default geometry of the sample RAM (also used by wave_display),
// the capture FSM state encoding and the sample-to-RAM conversion helper.
package wave_capture_pkg;

  localparam int unsigned WcNumSamples  = 256;   // samples per bank
  localparam int unsigned WcAddrW       = 8;     // log2(WcNumSamples)
  localparam int unsigned WcTrigTimeout = 1024;  // strobes in ARMED before forced trigger

  typedef enum logic [1:0] {
    WcArmed  = 2'd0,
    WcActive = 2'd1,
    WcWait   = 2'd2
  } wc_state_e;

  // Signed top byte to offset binary: 0x80 -> 0x00, 0x00 -> 0x80, 0x7F -> 0xFF.
  function automatic logic [7:0] to_offset_binary(input logic [7:0] top_byte);
    return top_byte ^ 8'h80;
  endfunction

endpackage

// File: rtl/zero_cross_detect.sv
// Trigger source for wave_capture.
// Tracks the sign of the previous sample and counts strobes while armed,
// asserting trigger (combinationally, one cycle, qualified by strobe) on a
// negative-to-non-negative crossing or when the timeout count is reached.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   strobe       new sample strobe
//   sample_neg   sign bit of the current sample
//   armed        capture FSM is waiting for a trigger
//   trigger      accept this strobe as sample 0 of a capture
module zero_cross_detect #(
  parameter int unsigned TRIG_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic sample_neg,
  input  logic armed,
  output logic trigger
);

  localparam int unsigned CntW = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;

  logic            prev_neg_q;
  logic [CntW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic            crossing, timed_out;

  always_comb begin
    crossing      = prev_neg_q && !sample_neg;
    timed_out     = (timeout_cnt_q == CntW'(TRIG_TIMEOUT - 1));
    trigger       = armed && strobe && (crossing || timed_out);
    timeout_cnt_d = timeout_cnt_q;
    if (trigger) begin
      timeout_cnt_d = '0;
    end else if (armed && strobe) begin
      timeout_cnt_d = timeout_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_neg_q    <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      // Sign history follows every strobe regardless of FSM state.
      if (strobe) prev_neg_q <= sample_neg;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

endmodule

// File: rtl/wave_capture.sv
// Capture controller for the double-banked waveform sample RAM.
// Arms on a rising zero crossing (or a forced trigger after a timeout),
// writes NUM_SAMPLES offset-binary bytes into the bank not being displayed,
// then flips read_index during display idle so the reader never sees a
// half-written bank. All RAM write outputs are registered.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   new_sample_ready    one-cycle strobe per audio sample
//   new_sample_in       signed 16-bit sample, valid with the strobe
//   wave_display_idle   display is in vertical blank
//   write_address       {bank, index} into the sample RAM
//   write_enable        one-cycle RAM write strobe
//   write_sample        unsigned byte to store
//   read_index          bank being displayed; writes go to ~read_index
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES  = wave_capture_pkg::WcNumSamples,
  parameter int unsigned ADDR_W       = wave_capture_pkg::WcAddrW,
  parameter int unsigned TRIG_TIMEOUT = wave_capture_pkg::WcTrigTimeout
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_sample_ready,
  input  logic [15:0]       new_sample_in,
  input  logic              wave_display_idle,
  output logic [ADDR_W:0]   write_address,
  output logic              write_enable,
  output logic [7:0]        write_sample,
  output logic              read_index
);

  wc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W:0]   waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              read_index_q, read_index_d;
  logic              trigger;
  logic              unused_sample_lsbs;

  assign unused_sample_lsbs = ^new_sample_in[7:0];

  zero_cross_detect #(
    .TRIG_TIMEOUT (TRIG_TIMEOUT)
  ) u_zero_cross_detect (
    .clk        (clk),
    .reset      (reset),
    .strobe     (new_sample_ready),
    .sample_neg (new_sample_in[15]),
    .armed      (state_q == WcArmed),
    .trigger    (trigger)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    read_index_d = read_index_q;
    unique case (state_q)
      WcArmed: begin
        if (trigger) begin
          we_d    = 1'b1;
          waddr_d = {~read_index_q, {ADDR_W{1'b0}}};
          wdata_d = to_offset_binary(new_sample_in[15:8]);
          count_d = ADDR_W'(1);
          state_d = WcActive;
        end
      end
      WcActive: begin
        if (new_sample_ready) begin
          we_d    = 1'b1;
          waddr_d = {~read_index_q, count_q};
          wdata_d = to_offset_binary(new_sample_in[15:8]);
          count_d = count_q + ADDR_W'(1);  // wraps to 0 after the last slot
          if (count_q == ADDR_W'(NUM_SAMPLES - 1)) state_d = WcWait;
        end
      end
      WcWait: begin
        // Strobes here are dropped; a strobe on the exit cycle cannot
        // trigger because the detector only fires while armed.
        if (wave_display_idle) begin
          read_index_d = ~read_index_q;
          state_d      = WcArmed;
        end
      end
      default: state_d = WcArmed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WcArmed;
      count_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      read_index_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      read_index_q <= read_index_d;
    end
  end

  assign write_address = waddr_q;
  assign write_enable  = we_q;
  assign write_sample  = wdata_q;
  assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  wave_capture dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  // One strobe for one cycle; returns 1 time unit after the accepting edge,
  // where the registered write outputs for this strobe are visible.
  task automatic drive(input logic [15:0] s);
    new_sample_ready = 1'b1;
    new_sample_in    = s;
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    new_sample_ready = 1'b0;
    new_sample_in = 16'h0000;
    wave_display_idle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (write_enable !== 1'b0) begin
      errors++; $display("FAIL reset_we: got %b want 0", write_enable);
    end
    vectors++;
    if (write_address !== 9'h000) begin
      errors++; $display("FAIL reset_addr: got %h want 000", write_address);
    end
    vectors++;
    if (write_sample !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h want 00", write_sample);
    end
    vectors++;
    if (read_index !== 1'b0) begin
      errors++; $display("FAIL reset_ri: got %b want 0", read_index);
    end
    reset = 1'b0;
  endtask

  task automatic test_timeout_quiet();
    for (int i = 0; i < 1023; i++) begin
      drive(16'h1000);
      vectors++;
      if (write_enable !== 1'b0) begin
        errors++; $display("FAIL quiet_no_write strobe %0d: we %b want 0", i, write_enable);
      end
    end
    drive(16'h1000);
    vectors++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'h90) begin
      errors++;
      $display("FAIL quiet_forced_1024: we %b addr %h data %h want 1 100 90",
               write_enable, write_address, write_sample);
    end
    pulse_reset();
    vectors++;
    if (write_enable !== 1'b0) begin
      errors++; $display("FAIL quiet_reset_we: got %b want 0", write_enable);
    end
  endtask

  task automatic test_crossing_capture();
    logic [7:0] b;
    drive(16'hFFFB);
    vectors++;
    if (write_enable !== 1'b0) begin
      errors++; $display("FAIL cross_neg_no_write: we %b want 0", write_enable);
    end
    drive(16'h1234);
    vectors++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'h92) begin
      errors++;
      $display("FAIL cross_first: we %b addr %h data %h want 1 100 92",
               write_enable, write_address, write_sample);
    end
    for (int i = 1; i < 256; i++) begin
      b = 8'(i);
      drive({b, 8'h00});
      vectors++;
      if (write_enable !== 1'b1 || write_address !== 9'(256 + i) ||
          write_sample !== (b ^ 8'h80)) begin
        errors++;
        $display("FAIL cross_write %0d: we %b addr %h data %h want 1 %h %h", i,
                 write_enable, write_address, write_sample, 9'(256 + i), b ^ 8'h80);
      end
    end
    drive(16'h1000);
    vectors++;
    if (write_enable !== 1'b0) begin
      errors++; $display("FAIL cross_stop: we %b want 0", write_enable);
    end
  endtask

  task automatic test_bank_swap();
    logic [7:0] b;
    wave_display_idle = 1'b0;
    for (int i = 0; i < 50; i++) begin
      drive(16'h1000);
      vectors++;
      if (write_enable !== 1'b0 || read_index !== 1'b0) begin
        errors++;
        $display("FAIL swap_hold %0d: we %b ri %b want 0 0", i, write_enable, read_index);
      end
    end
    wave_display_idle = 1'b1;
    @(posedge clk);
    #1;
    wave_display_idle = 1'b0;
    vectors++;
    if (read_index !== 1'b1) begin
      errors++; $display("FAIL swap_toggle: ri %b want 1", read_index);
    end
    drive(16'h8000);
    vectors++;
    if (write_enable !== 1'b0) begin
      errors++; $display("FAIL swap_neg_no_write: we %b want 0", write_enable);
    end
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      drive({b, 8'h00});
      vectors++;
      if (write_enable !== 1'b1 || write_address !== 9'(i) || write_sample !== (b ^ 8'h80)) begin
        errors++;
        $display("FAIL swap_bank0_write %0d: we %b addr %h data %h want 1 %h %h", i,
                 write_enable, write_address, write_sample, 9'(i), b ^ 8'h80);
      end
    end
    drive(16'h1000);
    vectors++;
    if (write_enable !== 1'b0) begin
      errors++; $display("FAIL swap_bank0_stop: we %b want 0", write_enable);
    end
  endtask

  task automatic test_forced_trigger();
    pulse_reset();
    for (int i = 0; i < 1023; i++) begin
      drive(16'h4000);
      vectors++;
      if (write_enable !== 1'b0) begin
        errors++; $display("FAIL forced_no_write %0d: we %b want 0", i, write_enable);
      end
    end
    for (int i = 0; i < 256; i++) begin
      drive(16'h4000);
      vectors++;
      if (write_enable !== 1'b1 || write_address !== 9'(256 + i) || write_sample !== 8'hC0) begin
        errors++;
        $display("FAIL forced_write %0d: we %b addr %h data %h want 1 %h c0", i,
                 write_enable, write_address, write_sample, 9'(256 + i));
      end
    end
    drive(16'h4000);
    vectors++;
    if (write_enable !== 1'b0) begin
      errors++; $display("FAIL forced_stop: we %b want 0", write_enable);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    pulse_reset();
    wave_display_idle = 1'b1;
    drive(16'hFFFB);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      drive({b, 8'h00});
      vectors++;
      if (write_enable !== 1'b1 || write_address !== 9'(256 + i) ||
          write_sample !== (b ^ 8'h80)) begin
        errors++;
        $display("FAIL b2b_write %0d: we %b addr %h data %h want 1 %h %h", i,
                 write_enable, write_address, write_sample, 9'(256 + i), b ^ 8'h80);
      end
    end
    vectors++;
    if (read_index !== 1'b0) begin
      errors++; $display("FAIL b2b_no_early_toggle: ri %b want 0", read_index);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (read_index !== 1'b1 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL b2b_toggle: ri %b we %b want 1 0", read_index, write_enable);
    end
    wave_display_idle = 1'b0;
  endtask

  task automatic test_reset_mid_capture();
    logic [7:0] b;
    drive(16'hFFFB);
    for (int i = 0; i < 100; i++) begin
      b = 8'(i);
      drive({b, 8'h00});
      vectors++;
      if (write_enable !== 1'b1 || write_address !== 9'(i)) begin
        errors++;
        $display("FAIL mid_write %0d: we %b addr %h want 1 %h", i,
                 write_enable, write_address, 9'(i));
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if (write_enable !== 1'b0 || read_index !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: we %b ri %b want 0 0", write_enable, read_index);
    end
    drive(16'hFFFB);
    drive(16'h0500);
    vectors++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'h85) begin
      errors++;
      $display("FAIL mid_restart: we %b addr %h data %h want 1 100 85",
               write_enable, write_address, write_sample);
    end
  endtask

  initial begin
    test_reset();
    test_timeout_quiet();
    test_crossing_capture();
    test_bank_swap();
    test_forced_trigger();
    test_back_to_back();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
